// File: rtl/dht11_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dht11_responder
// Brief   : DHT11 device emulator. Answers a host start pulse on the
//           open-drain line with the presence response and a 40-bit frame.
// Rev     : 1.0  initial release
// ============================================================================
module dht11_responder #(
    parameter int CLK_MHZ      = 100,
    parameter int START_MIN_US = 18000,
    parameter int WAIT_US      = 30,
    parameter int RESP_LOW_US  = 80,
    parameter int RESP_HIGH_US = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HIGH_US = 26,
    parameter int BIT1_HIGH_US = 70,
    parameter int END_LOW_US   = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    inout  wire        dht11_data,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves as low-time counter in IDLE and phase counter elsewhere.
    localparam int c_max_us = f_max(START_MIN_US, f_max(WAIT_US, f_max(RESP_LOW_US,
                              f_max(RESP_HIGH_US, f_max(BIT_LOW_US, f_max(BIT0_HIGH_US,
                              f_max(BIT1_HIGH_US, END_LOW_US)))))));
    localparam int c_cnt_w  = $clog2(c_max_us + 1);
    localparam int c_pre_w  = $clog2(CLK_MHZ + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_REL  = 3'd1,
        S_RESP_LOW  = 3'd2,
        S_RESP_HIGH = 3'd3,
        S_BIT_LOW   = 3'd4,
        S_BIT_HIGH  = 3'd5,
        S_END_LOW   = 3'd6
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [c_pre_w-1:0]   r_pre;
    logic [c_cnt_w-1:0]   r_us_cnt;
    logic [5:0]           r_bit;
    logic [39:0]          r_frame;
    logic                 r_drive_low;

    logic                 w_line;
    logic                 w_tick;
    logic                 w_start_ok;
    logic [7:0]           w_csum;
    int                   w_phase_us;
    logic [c_cnt_w-1:0]   w_phase_last;

    assign dht11_data   = r_drive_low ? 1'b0 : 1'bz;
    assign w_line       = r_sync[1];
    assign w_tick       = (r_pre == c_pre_w'(CLK_MHZ - 1));
    assign w_start_ok   = (r_us_cnt >= c_cnt_w'(START_MIN_US));
    assign w_csum       = hum_int + hum_dec + tmp_int + tmp_dec;
    assign w_phase_last = c_cnt_w'(w_phase_us - 1);

    // The bit being sent is always the MSB of the shifting snapshot.
    always_comb begin
        w_phase_us = 1;
        case (r_state)
            S_WAIT_REL:  w_phase_us = WAIT_US;
            S_RESP_LOW:  w_phase_us = RESP_LOW_US;
            S_RESP_HIGH: w_phase_us = RESP_HIGH_US;
            S_BIT_LOW:   w_phase_us = BIT_LOW_US;
            S_BIT_HIGH:  w_phase_us = r_frame[39] ? BIT1_HIGH_US : BIT0_HIGH_US;
            S_END_LOW:   w_phase_us = END_LOW_US;
            default:     w_phase_us = 1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_sync      <= 2'b11;
            r_pre       <= '0;
            r_us_cnt    <= '0;
            r_bit       <= 6'd0;
            r_frame     <= 40'd0;
            r_drive_low <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            r_sync <= {r_sync[0], dht11_data};
            done   <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_line) begin
                    // Prescaler held at zero while high so low time is measured exactly.
                    r_pre    <= '0;
                    r_us_cnt <= '0;
                    if (w_start_ok) begin
                        r_frame <= {hum_int, hum_dec, tmp_int, tmp_dec, w_csum};
                        r_bit   <= 6'd0;
                        busy    <= 1'b1;
                        r_state <= S_WAIT_REL;
                    end
                end else if (w_tick) begin
                    r_pre <= '0;
                    if (!w_start_ok) begin
                        r_us_cnt <= r_us_cnt + c_cnt_w'(1);
                    end
                end else begin
                    r_pre <= r_pre + c_pre_w'(1);
                end
            end else if (w_tick) begin
                r_pre <= '0;
                if (r_us_cnt == w_phase_last) begin
                    r_us_cnt <= '0;
                    case (r_state)
                        S_WAIT_REL: begin
                            r_state     <= S_RESP_LOW;
                            r_drive_low <= 1'b1;
                        end
                        S_RESP_LOW: begin
                            r_state     <= S_RESP_HIGH;
                            r_drive_low <= 1'b0;
                        end
                        S_RESP_HIGH: begin
                            r_state     <= S_BIT_LOW;
                            r_drive_low <= 1'b1;
                        end
                        S_BIT_LOW: begin
                            r_state     <= S_BIT_HIGH;
                            r_drive_low <= 1'b0;
                        end
                        S_BIT_HIGH: begin
                            r_frame     <= {r_frame[38:0], 1'b0};
                            r_bit       <= r_bit + 6'd1;
                            r_drive_low <= 1'b1;
                            r_state     <= (r_bit == 6'd39) ? S_END_LOW : S_BIT_LOW;
                        end
                        S_END_LOW: begin
                            r_state     <= S_IDLE;
                            r_drive_low <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            frame_cnt   <= frame_cnt + 8'd1;
                        end
                        default: begin
                            r_state     <= S_IDLE;
                            r_drive_low <= 1'b0;
                            busy        <= 1'b0;
                        end
                    endcase
                end else begin
                    r_us_cnt <= r_us_cnt + c_cnt_w'(1);
                end
            end else begin
                r_pre <= r_pre + c_pre_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dht11_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_dht11_responder
// Brief   : Self-checking bench for dht11_responder with scaled-down timing.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dht11_responder;

    localparam int c_clk_mhz   = 2;
    localparam int c_start_us  = 6;
    localparam int c_wait_us   = 2;
    localparam int c_resp_l_us = 2;
    localparam int c_resp_h_us = 2;
    localparam int c_bit_l_us  = 1;
    localparam int c_bit0_us   = 1;
    localparam int c_bit1_us   = 3;
    localparam int c_end_us    = 2;
    localparam int c_latency   = 3 + c_wait_us * c_clk_mhz;
    localparam int c_lat_max   = 60;
    localparam int c_run_max   = 100;
    localparam int c_frame_max = 1000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       host_low;
    wire        dht11_data;
    logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
    logic       busy, done;
    logic [7:0] frame_cnt;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_cnt;

    typedef struct {
        logic [7:0] hi, hd, ti, td;
        int         low_us;
        bit         valid;
        string      tag;
    } vec_t;
    vec_t vecs[5];

    pullup (dht11_data);
    assign dht11_data = host_low ? 1'b0 : 1'bz;
    always #5 clk = ~clk;

    dht11_responder #(
        .CLK_MHZ(c_clk_mhz), .START_MIN_US(c_start_us), .WAIT_US(c_wait_us),
        .RESP_LOW_US(c_resp_l_us), .RESP_HIGH_US(c_resp_h_us), .BIT_LOW_US(c_bit_l_us),
        .BIT0_HIGH_US(c_bit0_us), .BIT1_HIGH_US(c_bit1_us), .END_LOW_US(c_end_us)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dht11_data(dht11_data),
        .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic host_start(input int low_us);
        repeat (4) @(negedge clk);
        host_low = 1'b1;
        repeat (low_us * c_clk_mhz) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Full frame with waveform model; optional mid-frame byte change or reset.
    task automatic do_frame(input string tag, input int low_us, input int mut_run,
                            input logic [7:0] mut_val, input int rst_run);
        int         seg_exp[83];
        int         seg_got[83];
        logic [7:0] mb[5];
        logic [7:0] gb[5];
        int         lat, run, len, done_seen, bad_seg, first_bad, tot_exp, tot_got;
        logic       lvl, rel_done, rel_busy, b;
        mb[0] = hum_int; mb[1] = hum_dec; mb[2] = tmp_int; mb[3] = tmp_dec;
        mb[4] = 8'((int'(hum_int) + int'(hum_dec) + int'(tmp_int) + int'(tmp_dec)) % 256);
        seg_exp[0] = c_resp_l_us * c_clk_mhz;
        seg_exp[1] = c_resp_h_us * c_clk_mhz;
        for (int i = 0; i < 40; i++) begin
            b = mb[i / 8][7 - (i % 8)];
            seg_exp[2 + 2 * i] = c_bit_l_us * c_clk_mhz;
            seg_exp[3 + 2 * i] = (b ? c_bit1_us : c_bit0_us) * c_clk_mhz;
        end
        seg_exp[82] = c_end_us * c_clk_mhz;

        host_start(low_us);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (dht11_data !== 1'b0 && lat < c_lat_max);
        check({tag, " response latency"}, lat, c_latency);
        check({tag, " busy during response"}, busy, 1);
        if (dht11_data !== 1'b0) return;

        run = 0; len = 1; lvl = 1'b0; done_seen = 0; rel_done = 1'b0; rel_busy = 1'b1;
        while (run < 83) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (dht11_data === lvl) begin
                len++;
                if (len > c_run_max) begin
                    check({tag, " phase length bound"}, len, c_run_max);
                    return;
                end
            end else begin
                seg_got[run] = len;
                run++;
                len = 1;
                lvl = dht11_data;
                if (run == 83) begin
                    rel_done = done;
                    rel_busy = busy;
                end
                if (run == mut_run) hum_int = mut_val;
                if (run == rst_run) begin
                    reset_n = 1'b0;
                    #1;
                    check({tag, " line released"}, dht11_data, 1);
                    check({tag, " busy"}, busy, 0);
                    check({tag, " done"}, done, 0);
                    check({tag, " frame_cnt"}, frame_cnt, 0);
                    exp_cnt = 8'd0;
                    repeat (3) @(negedge clk);
                    reset_n = 1'b1;
                    return;
                end
            end
        end
        @(negedge clk);
        if (done === 1'b1) done_seen++;
        check({tag, " done at release"}, rel_done, 1);
        check({tag, " busy falls with done"}, rel_busy, 0);
        check({tag, " done pulse cycles"}, done_seen, 1);

        bad_seg = 0; first_bad = -1; tot_exp = 0; tot_got = 0;
        for (int i = 0; i < 83; i++) begin
            tot_exp += seg_exp[i];
            tot_got += seg_got[i];
            if (seg_got[i] != seg_exp[i]) begin
                bad_seg++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (first_bad >= 0)
            $display("  %s: first wrong phase %0d lasted %0d cycles, model %0d",
                     tag, first_bad, seg_got[first_bad], seg_exp[first_bad]);
        check({tag, " phases with wrong width"}, bad_seg, 0);
        check({tag, " frame length cycles"}, tot_got, tot_exp);
        for (int k = 0; k < 5; k++) gb[k] = 8'd0;
        for (int i = 0; i < 40; i++)
            gb[i / 8][7 - (i % 8)] = (seg_got[3 + 2 * i] * 2 > (c_bit0_us + c_bit1_us) * c_clk_mhz);
        for (int k = 0; k < 5; k++)
            check($sformatf("%s byte%0d", tag, k), gb[k], mb[k]);
        exp_cnt = exp_cnt + 8'd1;
        check({tag, " frame_cnt"}, frame_cnt, exp_cnt);
    endtask

    task automatic short_start(input string tag, input int low_us);
        int lows, busys;
        host_start(low_us);
        lows = 0; busys = 0;
        repeat (c_latency + 20) begin
            @(negedge clk);
            if (dht11_data !== 1'b1) lows++;
            if (busy === 1'b1) busys++;
        end
        check({tag, " driven-low cycles"}, lows, 0);
        check({tag, " busy cycles"}, busys, 0);
        check({tag, " frame_cnt"}, frame_cnt, exp_cnt);
    endtask

    task automatic fast_frame(output bit got);
        got = 1'b0;
        host_start(2 * c_start_us);
        for (int t = 0; t < c_frame_max && !got; t++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        if (got) exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        int  lows, busys;
        bit  ok;
        reset_n = 1'b0; host_low = 1'b0; exp_cnt = 8'd0;
        hum_int = 8'd0; hum_dec = 8'd0; tmp_int = 8'd0; tmp_dec = 8'd0;
        repeat (3) @(negedge clk);
        check("reset line", dht11_data, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset frame_cnt", frame_cnt, 0);
        reset_n = 1'b1;
        lows = 0; busys = 0;
        repeat (40) begin
            @(negedge clk);
            if (dht11_data !== 1'b1) lows++;
            if (busy === 1'b1 || done === 1'b1) busys++;
        end
        check("idle after reset, driven-low cycles", lows, 0);
        check("idle after reset, busy/done cycles", busys, 0);

        vecs[0] = '{hi: 8'd45,  hd: 8'd0,   ti: 8'd27, td: 8'd0,   low_us: 2 * c_start_us,  valid: 1'b1, tag: "valid 45/27"};
        vecs[1] = '{hi: 8'd45,  hd: 8'd0,   ti: 8'd27, td: 8'd0,   low_us: c_start_us / 2,  valid: 1'b0, tag: "short start"};
        vecs[2] = '{hi: 8'd200, hd: 8'd100, ti: 8'd50, td: 8'd10,  low_us: 2 * c_start_us,  valid: 1'b1, tag: "checksum wrap"};
        vecs[3] = '{hi: 8'hA5,  hd: 8'h5A,  ti: 8'hFF, td: 8'h01,  low_us: 10 * c_start_us, valid: 1'b1, tag: "long low"};
        vecs[4] = '{hi: 8'd1,   hd: 8'd2,   ti: 8'd3,  td: 8'd4,   low_us: c_start_us - 2,  valid: 1'b0, tag: "short start 2"};
        for (int v = 0; v < 5; v++) begin
            hum_int = vecs[v].hi; hum_dec = vecs[v].hd;
            tmp_int = vecs[v].ti; tmp_dec = vecs[v].td;
            if (vecs[v].valid) do_frame(vecs[v].tag, vecs[v].low_us, -1, 8'd0, -1);
            else               short_start(vecs[v].tag, vecs[v].low_us);
        end

        hum_int = 8'd45; hum_dec = 8'd0; tmp_int = 8'd27; tmp_dec = 8'd0;
        do_frame("snapshot", 2 * c_start_us, 12, 8'd99, -1);

        for (int r = 0; r < 4; r++) begin
            hum_int = 8'($urandom_range(0, 255)); hum_dec = 8'($urandom_range(0, 255));
            tmp_int = 8'($urandom_range(0, 255)); tmp_dec = 8'($urandom_range(0, 255));
            do_frame($sformatf("random%0d", r), 2 * c_start_us + r, -1, 8'd0, -1);
        end

        hum_int = 8'h33; hum_dec = 8'hCC; tmp_int = 8'h0F; tmp_dec = 8'hF0;
        do_frame("reset mid-frame", 2 * c_start_us, -1, 8'd0, 42);
        do_frame("after reset", 2 * c_start_us, -1, 8'd0, -1);

        hum_int = 8'd0; hum_dec = 8'd0; tmp_int = 8'd0; tmp_dec = 8'd0;
        ok = 1'b1;
        while (ok && exp_cnt != 8'd255) fast_frame(ok);
        check("preload frames completed", ok, 1);
        check("frame_cnt before wrap", frame_cnt, 255);
        hum_int = 8'd12; tmp_int = 8'd34;
        do_frame("wrap frame", 2 * c_start_us, -1, 8'd0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, compared %0d, mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dht11_responder.md
# dht11_responder

Device-side emulator of the DHT11 single-wire protocol: it waits for a host start pulse on the open-drain data line, then answers with the 80 µs/80 µs presence response and a 40-bit humidity/temperature frame with checksum. It sits in the fan project's bench and hardware-in-loop setup as the counterpart to the on-board DHT11 reader, so the fan controller and display path can run against programmable, repeatable sensor values.

## Interface
- CLK_MHZ, 100, clock cycles per microsecond
- START_MIN_US, 18000, minimum host low time accepted as a start request
- WAIT_US, 30, delay from host release to the start of the response
- RESP_LOW_US, 80, response low phase
- RESP_HIGH_US, 80, response high (released) phase
- BIT_LOW_US, 50, low phase preceding every data bit
- BIT0_HIGH_US, 26, released phase for a 0 bit
- BIT1_HIGH_US, 70, released phase for a 1 bit
- END_LOW_US, 50, final low phase after bit 39

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- dht11_data  inout  1  open-drain line: driven 0 or high-Z, never driven 1
- hum_int  input  8  humidity integer byte
- hum_dec  input  8  humidity decimal byte
- tmp_int  input  8  temperature integer byte
- tmp_dec  input  8  temperature decimal byte
- busy  output  1  high from WAIT_REL entry through END_LOW exit
- done  output  1  one-cycle pulse when a frame completes
- frame_cnt  output  8  count of completed frames, wraps 255→0

## Operation
- Line input passes through a 2-flop synchronizer. A registered drive_low sets dht11_data = drive_low ? 0 : Z.
- A µs prescaler counts 0..CLK_MHZ-1 and clears on every state entry. Phase counters count µs ticks, so each driven phase lasts exactly N·CLK_MHZ clocks.
- IDLE: drive released. While the synchronized line is low, the low-time counter increments per µs and saturates at START_MIN_US. It clears whenever the line is high.
  - On a synchronized rising edge with count ≥ START_MIN_US: snapshot the four input bytes, compute checksum = (hum_int + hum_dec + tmp_int + tmp_dec) mod 256, and go to WAIT_REL.
  - On a rising edge with a shorter count: ignore it and stay in IDLE.
- WAIT_REL: released for WAIT_US, then go to RESP_LOW.
- RESP_LOW: drive low for RESP_LOW_US.
- RESP_HIGH: released for RESP_HIGH_US.
- BIT_LOW: drive low for BIT_LOW_US.
- BIT_HIGH: released for BIT1_HIGH_US or BIT0_HIGH_US, depending on the current bit. The bit index increments, then go to BIT_LOW, or to END_LOW after bit 39.
- Bit order: byte order hum_int, hum_dec, tmp_int, tmp_dec, checksum; MSB first within each byte.
- END_LOW: drive low for END_LOW_US, then release and return to IDLE. In the same cycle, pulse done and increment frame_cnt.
- Input bytes changing mid-frame have no effect; only the snapshot is transmitted.
- The line is not monitored outside IDLE. Host activity during a frame is ignored.

## Timing
- Reset values: drive_low=0 (line Z), busy=0, done=0, frame_cnt=0, state IDLE, all counters 0. Reset acts immediately, including mid-frame: the line is released asynchronously.
- Host release edge on the pin → first driven-low cycle: exactly 3 + WAIT_US·CLK_MHZ clocks (2 synchronizer stages plus 1 registered transition).
- Full frame length from RESP_LOW entry: (RESP_LOW+RESP_HIGH+40·BIT_LOW+Σbit highs+END_LOW) µs, exact to the clock.
- done is high for exactly 1 cycle, coincident with the release at the end of END_LOW. busy falls in that same cycle.
- The low-time counter must not overflow. It saturates, so a host low held indefinitely is still a valid start.

## Test plan
- Reset: hold reset_n=0 → line Z, busy=0, done=0, frame_cnt=0. Release reset with the line idle high → no activity.
- Valid frame: hum_int=45, tmp_int=27, decimals=0; host low 20 ms then release → low 80 µs, high 80 µs, then bytes 0x2D 0x00 0x1B 0x00 0x48. Bit widths are 50+26 µs or 50+70 µs. Expect done pulse and frame_cnt=1.
- Short start: host low 10 ms then release → no response, busy stays 0, frame_cnt unchanged.
- Snapshot and checksum wrap:
  - Change hum_int 45→99 during bit 5 → frame still carries 0x2D.
  - Next frame with hum 200/100, tmp 50/10 → checksum 0x68 (360 mod 256).
- Reset mid-frame: assert reset_n=0 during bit 20 → line Z within the same cycle, busy=0. After reset release, a new 20 ms start yields a complete, correct frame.
- Counter wrap: preload via 255 completed frames → the 256th done pulse sets frame_cnt to 0.
